// File: rtl/tile_scheduler_pkg.sv
// Shared definitions for the tiled-GEMM scheduler: width defaults and FSM state encoding.
package tile_scheduler_pkg;

   localparam int DEF_AWIDTH     = 11;
   localparam int DEF_STEP_WIDTH = 16;
   localparam int DEF_TCNT_WIDTH = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_PRST   = 3'd1;
   localparam logic [2:0] ST_LAUNCH = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_ADV    = 3'd4;
   localparam logic [2:0] ST_FIN    = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_PRST   = ST_PRST,
      S_LAUNCH = ST_LAUNCH,
      S_WAIT   = ST_WAIT,
      S_ADV    = ST_ADV,
      S_FIN    = ST_FIN
   } state_t;

endpackage

// File: rtl/tile_addr_gen.sv
// Tile loop counters and incremental A/B/C address accumulators (m outer, n middle, k inner).
module tile_addr_gen
  import tile_scheduler_pkg::*;
#(
  parameter int AWIDTH     = DEF_AWIDTH,
  parameter int TCNT_WIDTH = DEF_TCNT_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  adv_k,
  input  logic                  wrap_k,
  input  logic                  wrap_n,
  input  logic [TCNT_WIDTH-1:0] num_tiles_m,
  input  logic [TCNT_WIDTH-1:0] num_tiles_n,
  input  logic [TCNT_WIDTH-1:0] num_tiles_k,
  input  logic [AWIDTH-1:0]     base_a,
  input  logic [AWIDTH-1:0]     base_b,
  input  logic [AWIDTH-1:0]     base_c,
  input  logic [STEP_WIDTH-1:0] a_m_step,
  input  logic [STEP_WIDTH-1:0] a_k_step,
  input  logic [STEP_WIDTH-1:0] b_k_step,
  input  logic [STEP_WIDTH-1:0] b_n_step,
  input  logic [STEP_WIDTH-1:0] c_m_step,
  input  logic [STEP_WIDTH-1:0] c_n_step,
  output logic [AWIDTH-1:0]     addr_a,
  output logic [AWIDTH-1:0]     addr_b,
  output logic [AWIDTH-1:0]     addr_c,
  output logic                  first_k,
  output logic                  last_k,
  output logic                  last_n,
  output logic                  last_m
);

  logic [TCNT_WIDTH-1:0] cnt_m, cnt_n, cnt_k;
  logic [TCNT_WIDTH-1:0] m, n, k;
  logic [AWIDTH-1:0]     am, ak, bk, bn, cm, cn;
  logic [AWIDTH-1:0]     b_base;
  logic [AWIDTH-1:0]     a_row, b_col, c_row;
  logic [AWIDTH-1:0]     a_cur, b_cur, c_cur;

  // Row/column anchors let a k or n wrap restart from the right place without multiplying.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_m <= '0; cnt_n <= '0; cnt_k <= '0;
      m <= '0; n <= '0; k <= '0;
      am <= '0; ak <= '0; bk <= '0; bn <= '0; cm <= '0; cn <= '0;
      b_base <= '0;
      a_row <= '0; b_col <= '0; c_row <= '0;
      a_cur <= '0; b_cur <= '0; c_cur <= '0;
    end else if (init) begin
      cnt_m <= num_tiles_m; cnt_n <= num_tiles_n; cnt_k <= num_tiles_k;
      m <= '0; n <= '0; k <= '0;
      am <= AWIDTH'(a_m_step); ak <= AWIDTH'(a_k_step);
      bk <= AWIDTH'(b_k_step); bn <= AWIDTH'(b_n_step);
      cm <= AWIDTH'(c_m_step); cn <= AWIDTH'(c_n_step);
      b_base <= base_b;
      a_row <= base_a; b_col <= base_b; c_row <= base_c;
      a_cur <= base_a; b_cur <= base_b; c_cur <= base_c;
    end else if (adv_k) begin
      k     <= k + TCNT_WIDTH'(1);
      a_cur <= a_cur + ak;
      b_cur <= b_cur + bk;
    end else if (wrap_k) begin
      k     <= '0;
      n     <= n + TCNT_WIDTH'(1);
      a_cur <= a_row;
      b_col <= b_col + bn;
      b_cur <= b_col + bn;
      c_cur <= c_cur + cn;
    end else if (wrap_n) begin
      k     <= '0;
      n     <= '0;
      m     <= m + TCNT_WIDTH'(1);
      a_row <= a_row + am;
      a_cur <= a_row + am;
      b_col <= b_base;
      b_cur <= b_base;
      c_row <= c_row + cm;
      c_cur <= c_row + cm;
    end
  end

  assign addr_a  = a_cur;
  assign addr_b  = b_cur;
  assign addr_c  = c_cur;
  assign first_k = (k == '0);
  assign last_k  = (k == cnt_k - TCNT_WIDTH'(1));
  assign last_n  = (n == cnt_n - TCNT_WIDTH'(1));
  assign last_m  = (m == cnt_m - TCNT_WIDTH'(1));

endmodule

// File: rtl/tile_scheduler.sv
// Job-level sequencer: walks every (m,n,k) tile, clearing the PEs and launching the tile engine for each.
module tile_scheduler
  import tile_scheduler_pkg::*;
#(
  parameter int AWIDTH     = DEF_AWIDTH,
  parameter int TCNT_WIDTH = DEF_TCNT_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [TCNT_WIDTH-1:0] num_tiles_m,
  input  logic [TCNT_WIDTH-1:0] num_tiles_n,
  input  logic [TCNT_WIDTH-1:0] num_tiles_k,
  input  logic [AWIDTH-1:0]     base_a,
  input  logic [AWIDTH-1:0]     base_b,
  input  logic [AWIDTH-1:0]     base_c,
  input  logic [STEP_WIDTH-1:0] a_m_step,
  input  logic [STEP_WIDTH-1:0] a_k_step,
  input  logic [STEP_WIDTH-1:0] b_k_step,
  input  logic [STEP_WIDTH-1:0] b_n_step,
  input  logic [STEP_WIDTH-1:0] c_m_step,
  input  logic [STEP_WIDTH-1:0] c_n_step,
  input  logic                  tile_done,
  output logic                  tile_start,
  output logic                  pe_reset,
  output logic [AWIDTH-1:0]     address_mat_a,
  output logic [AWIDTH-1:0]     address_mat_b,
  output logic [AWIDTH-1:0]     address_mat_c,
  output logic                  add_accum_to_output,
  output logic                  save_output_to_accum,
  output logic                  busy,
  output logic                  done
);

  state_t state, state_next;
  logic   start_d;
  logic   accept, any_zero;
  logic   init, adv_k, wrap_k, wrap_n;
  logic   first_k, last_k, last_n, last_m;
  logic   in_tile;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      start_d <= 1'b0;
    end else begin
      state   <= state_next;
      start_d <= start;
    end
  end

  assign accept   = (state == S_IDLE) && start && !start_d;
  assign any_zero = (num_tiles_m == '0) || (num_tiles_n == '0) || (num_tiles_k == '0);

  always_comb begin
    state_next = state;
    init       = 1'b0;
    adv_k      = 1'b0;
    wrap_k     = 1'b0;
    wrap_n     = 1'b0;
    pe_reset   = 1'b0;
    tile_start = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          init       = 1'b1;
          state_next = any_zero ? S_FIN : S_PRST;
        end
      end
      S_PRST: begin
        pe_reset   = 1'b1;
        state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        tile_start = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (tile_done) state_next = S_ADV;
      end
      S_ADV: begin
        if (last_k && last_n && last_m) begin
          state_next = S_FIN;
        end else begin
          adv_k      = !last_k;
          wrap_k     = last_k && !last_n;
          wrap_n     = last_k && last_n;
          state_next = S_PRST;
        end
      end
      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Flags follow the k position of the tile in flight and are forced low outside a tile.
  assign in_tile              = (state == S_PRST) || (state == S_LAUNCH) ||
                                (state == S_WAIT) || (state == S_ADV);
  assign add_accum_to_output  = in_tile && !first_k;
  assign save_output_to_accum = in_tile && !last_k;
  assign busy                 = (state != S_IDLE);

  tile_addr_gen #(
    .AWIDTH     (AWIDTH),
    .TCNT_WIDTH (TCNT_WIDTH),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .adv_k       (adv_k),
    .wrap_k      (wrap_k),
    .wrap_n      (wrap_n),
    .num_tiles_m (num_tiles_m),
    .num_tiles_n (num_tiles_n),
    .num_tiles_k (num_tiles_k),
    .base_a      (base_a),
    .base_b      (base_b),
    .base_c      (base_c),
    .a_m_step    (a_m_step),
    .a_k_step    (a_k_step),
    .b_k_step    (b_k_step),
    .b_n_step    (b_n_step),
    .c_m_step    (c_m_step),
    .c_n_step    (c_n_step),
    .addr_a      (address_mat_a),
    .addr_b      (address_mat_b),
    .addr_c      (address_mat_c),
    .first_k     (first_k),
    .last_k      (last_k),
    .last_n      (last_n),
    .last_m      (last_m)
  );

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: scripted cycle timeline plus a nested-loop tile model.
module tb_tile_scheduler;
  localparam int AW = 11;
  localparam int TW = 8;
  localparam int SW = 16;

  localparam int PH_PRST   = 0;
  localparam int PH_LAUNCH = 1;
  localparam int PH_WAIT   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [TW-1:0] num_tiles_m, num_tiles_n, num_tiles_k;
  logic [AW-1:0] base_a, base_b, base_c;
  logic [SW-1:0] a_m_step, a_k_step, b_k_step, b_n_step, c_m_step, c_n_step;
  logic          tile_done;
  logic          tile_start, pe_reset, add_accum_to_output, save_output_to_accum, busy, done;
  logic [AW-1:0] address_mat_a, address_mat_b, address_mat_c;

  typedef struct {
    int            m, n, k;
    logic [AW-1:0] ba, bb, bc;
    logic [SW-1:0] am, ak, bk, bn, cm, cn;
  } cfg_t;

  typedef struct {
    logic [AW-1:0] a, b, c;
    logic          add, save;
  } tile_t;

  tile_t model_q[$];

  int n_compared = 0;
  int n_failed   = 0;
  int cycle      = 0;
  int start_pulses = 0;

  logic          check_en = 1'b0;
  logic          exp_pe_reset, exp_tile_start, exp_busy, exp_done, exp_add, exp_save;
  logic          exp_addr_valid, exp_flag_valid;
  logic [AW-1:0] exp_a, exp_b, exp_c;

  always #5 clk = ~clk;

  tile_scheduler dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .num_tiles_m          (num_tiles_m),
    .num_tiles_n          (num_tiles_n),
    .num_tiles_k          (num_tiles_k),
    .base_a               (base_a),
    .base_b               (base_b),
    .base_c               (base_c),
    .a_m_step             (a_m_step),
    .a_k_step             (a_k_step),
    .b_k_step             (b_k_step),
    .b_n_step             (b_n_step),
    .c_m_step             (c_m_step),
    .c_n_step             (c_n_step),
    .tile_done            (tile_done),
    .tile_start           (tile_start),
    .pe_reset             (pe_reset),
    .address_mat_a        (address_mat_a),
    .address_mat_b        (address_mat_b),
    .address_mat_c        (address_mat_c),
    .add_accum_to_output  (add_accum_to_output),
    .save_output_to_accum (save_output_to_accum),
    .busy                 (busy),
    .done                 (done)
  );

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      if (n_failed <= 40)
        $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, actual, expected);
    end
  endtask

  // Single compare process: every cycle, outputs against the scripted expectation.
  always @(negedge clk) begin
    if (tile_start === 1'b1) start_pulses++;
    if (check_en) begin
      check_output("pe_reset", 32'(pe_reset), 32'(exp_pe_reset));
      check_output("tile_start", 32'(tile_start), 32'(exp_tile_start));
      check_output("busy", 32'(busy), 32'(exp_busy));
      check_output("done", 32'(done), 32'(exp_done));
      if (exp_flag_valid) begin
        check_output("add_accum", 32'(add_accum_to_output), 32'(exp_add));
        check_output("save_accum", 32'(save_output_to_accum), 32'(exp_save));
      end
      if (exp_addr_valid) begin
        check_output("addr_a", 32'(address_mat_a), 32'(exp_a));
        check_output("addr_b", 32'(address_mat_b), 32'(exp_b));
        check_output("addr_c", 32'(address_mat_c), 32'(exp_c));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic prst, input logic launch, input logic bsy, input logic dn);
    exp_pe_reset   = prst;
    exp_tile_start = launch;
    exp_busy       = bsy;
    exp_done       = dn;
    exp_add        = 1'b0;
    exp_save       = 1'b0;
    exp_flag_valid = 1'b1;
    exp_addr_valid = 1'b0;
  endtask

  task automatic set_tile_exp(input tile_t t, input int phase);
    set_exp(phase == PH_PRST, phase == PH_LAUNCH, 1'b1, 1'b0);
    exp_add        = t.add;
    exp_save       = t.save;
    exp_addr_valid = 1'b1;
    exp_a          = t.a;
    exp_b          = t.b;
    exp_c          = t.c;
  endtask

  task automatic set_reset_exp();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    exp_addr_valid = 1'b1;
    exp_a = '0;
    exp_b = '0;
    exp_c = '0;
  endtask

  // Expected tile sequence straight from the address/flag formulas.
  task automatic build_model(input cfg_t c);
    tile_t t;
    model_q.delete();
    for (int mi = 0; mi < c.m; mi++)
      for (int ni = 0; ni < c.n; ni++)
        for (int ki = 0; ki < c.k; ki++) begin
          t.a = AW'(int'(c.ba) + mi * int'(c.am) + ki * int'(c.ak));
          t.b = AW'(int'(c.bb) + ki * int'(c.bk) + ni * int'(c.bn));
          t.c = AW'(int'(c.bc) + mi * int'(c.cm) + ni * int'(c.cn));
          if (c.k == 1)            begin t.add = 1'b0; t.save = 1'b0; end
          else if (ki == 0)        begin t.add = 1'b0; t.save = 1'b1; end
          else if (ki == c.k - 1)  begin t.add = 1'b1; t.save = 1'b0; end
          else                     begin t.add = 1'b1; t.save = 1'b1; end
          model_q.push_back(t);
        end
  endtask

  task automatic scramble_inputs();
    num_tiles_m = TW'($urandom); num_tiles_n = TW'($urandom); num_tiles_k = TW'($urandom);
    base_a = AW'($urandom); base_b = AW'($urandom); base_c = AW'($urandom);
    a_m_step = SW'($urandom); a_k_step = SW'($urandom); b_k_step = SW'($urandom);
    b_n_step = SW'($urandom); c_m_step = SW'($urandom); c_n_step = SW'($urandom);
  endtask

  // One job: start edge at cycle 0, then every later cycle scripted from the model.
  task automatic apply_stimulus(input cfg_t c, input int abort_tile, input int glitch_tile);
    int d, w;
    build_model(c);
    start_pulses = 0;
    num_tiles_m = TW'(c.m); num_tiles_n = TW'(c.n); num_tiles_k = TW'(c.k);
    base_a = c.ba; base_b = c.bb; base_c = c.bc;
    a_m_step = c.am; a_k_step = c.ak; b_k_step = c.bk;
    b_n_step = c.bn; c_m_step = c.cm; c_n_step = c.cn;
    start = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    start = 1'b0;
    scramble_inputs();
    foreach (model_q[i]) begin
      set_tile_exp(model_q[i], PH_PRST);
      next_cycle();
      d = $urandom_range(0, 3);
      w = (d == 0) ? 1 : d;
      set_tile_exp(model_q[i], PH_LAUNCH);
      tile_done = (d == 0);
      next_cycle();
      for (int j = 1; j <= w; j++) begin
        set_tile_exp(model_q[i], PH_WAIT);
        tile_done = (j == w);
        if (i == abort_tile && j == 1) begin
          tile_done = 1'b0;
          reset = 1'b1;
          next_cycle();
          reset = 1'b0;
          set_reset_exp();
          for (int r = 0; r < 4; r++) next_cycle();
          check_output("abort_start_count", 32'(start_pulses), 32'(i + 1));
          return;
        end
        if (i == glitch_tile && j == 1) start = 1'b1;
        next_cycle();
      end
      tile_done = 1'b0;
      start = 1'b0;
      set_exp(1'b0, 1'b0, 1'b1, 1'b0);
      exp_flag_valid = 1'b0;
      next_cycle();
    end
    if (model_q.size() == 0) begin
      set_exp(1'b0, 1'b0, 1'b1, 1'b1);
      next_cycle();
    end else begin
      set_exp(1'b0, 1'b0, 1'b1, 1'b1);
      next_cycle();
    end
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    check_output("tile_start_count", 32'(start_pulses), 32'(model_q.size()));
  endtask

  function automatic cfg_t make_cfg(input int m, input int n, input int k,
                                    input int ba, input int bb, input int bc);
    cfg_t c;
    c.m = m; c.n = n; c.k = k;
    c.ba = AW'(ba); c.bb = AW'(bb); c.bc = AW'(bc);
    c.am = '0; c.ak = '0; c.bk = '0; c.bn = '0; c.cm = '0; c.cn = '0;
    return c;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cfg_t c;
    reset = 1'b1;
    start = 1'b0;
    tile_done = 1'b0;
    scramble_inputs();
    next_cycle();
    set_reset_exp();
    check_en = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);

    // Single tile.
    c = make_cfg(1, 1, 1, 'h10, 'h20, 'h30);
    apply_stimulus(c, -1, -1);
    check_output("pin_single_a", 32'(model_q[0].a), 32'h10);
    check_output("pin_single_c", 32'(model_q[0].c), 32'h30);
    check_output("pin_single_flags", 32'({model_q[0].add, model_q[0].save}), 32'b00);

    // K=3 accumulation chain.
    c = make_cfg(1, 1, 3, 'h100, 'h200, 'h40);
    c.ak = 16'd4; c.bk = 16'd4;
    apply_stimulus(c, -1, -1);
    check_output("pin_k3_a2", 32'(model_q[2].a), 32'h108);
    check_output("pin_k3_flags0", 32'({model_q[0].add, model_q[0].save}), 32'b01);
    check_output("pin_k3_flags1", 32'({model_q[1].add, model_q[1].save}), 32'b11);
    check_output("pin_k3_flags2", 32'({model_q[2].add, model_q[2].save}), 32'b10);

    // 2x2 output tiles, C order.
    c = make_cfg(2, 2, 1, 0, 0, 0);
    c.cm = 16'd8; c.cn = 16'd4;
    apply_stimulus(c, -1, -1);
    check_output("pin_c_order1", 32'(model_q[1].c), 32'd4);
    check_output("pin_c_order2", 32'(model_q[2].c), 32'd8);
    check_output("pin_c_order3", 32'(model_q[3].c), 32'd12);

    // Zero count: straight to FIN.
    c = make_cfg(2, 0, 2, 1, 2, 3);
    apply_stimulus(c, -1, -1);

    // Address wrap at 2^AWIDTH.
    c = make_cfg(1, 1, 2, 'h7FC, 0, 0);
    c.ak = 16'd8;
    apply_stimulus(c, -1, -1);
    check_output("pin_wrap_a1", 32'(model_q[1].a), 32'h004);

    // Start edge mid-job is ignored.
    c = make_cfg(1, 1, 3, 'h55, 'h66, 'h77);
    c.ak = 16'd3; c.bk = 16'd5;
    apply_stimulus(c, -1, 1);

    // Reset during WAIT of the second tile.
    c = make_cfg(1, 1, 3, 'h11, 'h22, 'h33);
    c.ak = 16'd1;
    apply_stimulus(c, 1, -1);

    // Long k run with truncated steps.
    c = make_cfg(1, 2, 130, $urandom, $urandom, $urandom);
    c.am = SW'($urandom); c.ak = SW'($urandom); c.bk = SW'($urandom);
    c.bn = SW'($urandom); c.cm = SW'($urandom); c.cn = SW'($urandom);
    apply_stimulus(c, -1, -1);

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      c = make_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
                   $urandom, $urandom, $urandom);
      c.am = SW'($urandom); c.ak = SW'($urandom); c.bk = SW'($urandom);
      c.bn = SW'($urandom); c.cm = SW'($urandom); c.cn = SW'($urandom);
      apply_stimulus(c, -1, ($urandom_range(0, 3) == 0) ? 0 : -1);
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
